// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: keypad entry sequencer for a calculator.
// Builds decimal operands digit by digit in a shared entry register (mag, cnt, neg), captures
// operator and operands A/B, pulses alu_start once and waits for alu_done. The result is held
// for display and chained as operand A when an operator follows it.
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   digit_stb/digit             digit key strobe and BCD value (>9 ignored)
//   op_stb/op_sel               operator key strobe and operator code
//   eq_stb, neg_stb, clr_stb    '=', sign-toggle and clear key strobes
//   alu_start/alu_a/alu_b/alu_op  ALU request (start is a one-cycle pulse)
//   alu_done/alu_result         ALU completion handshake and result
//   disp_value                  registered display value
//   state, err                  debug state encoding, error flag
module calc_entry_ctrl #(
   parameter int unsigned MAX_DIGITS = 8,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        digit_stb,
   input  logic [3:0]  digit,
   input  logic        op_stb,
   input  logic [1:0]  op_sel,
   input  logic        eq_stb,
   input  logic        neg_stb,
   input  logic        clr_stb,
   output logic        alu_start,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [1:0]  alu_op,
   input  logic        alu_done,
   input  logic [31:0] alu_result,
   output logic [31:0] disp_value,
   output logic [2:0]  state,
   output logic        err
);

   localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);

   typedef enum logic [2:0] {
      StEnterA = 3'd0,
      StEnterB = 3'd1,
      StWaitAlu = 3'd2,
      StShow   = 3'd3,
      StErr    = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       mag_q, mag_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic [31:0]       result_q, result_d;
   logic [31:0]       alu_a_q, alu_a_d;
   logic [31:0]       alu_b_q, alu_b_d;
   logic [1:0]        alu_op_q, alu_op_d;
   logic              alu_start_q, alu_start_d;
   logic [31:0]       disp_q, disp_d;
   logic [31:0]       tmo_q, tmo_d;

   function automatic logic [31:0] entry_val(input logic [31:0] m, input logic n);
      return n ? (~m + 32'd1) : m;
   endfunction

   logic digit_ok;
   assign digit_ok = digit_stb && (digit <= 4'd9);

   always_comb begin
      state_d     = state_q;
      mag_d       = mag_q;
      cnt_d       = cnt_q;
      neg_d       = neg_q;
      result_d    = result_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      alu_start_d = 1'b0;
      tmo_d       = tmo_q;

      // Strobe priority: clr > eq > op > neg > digit; a higher strobe drops the lower ones
      // even when it has no effect in the current state.
      if (clr_stb) begin
         state_d  = StEnterA;
         mag_d    = '0;
         cnt_d    = '0;
         neg_d    = 1'b0;
         result_d = '0;
         alu_a_d  = '0;
         alu_b_d  = '0;
         alu_op_d = '0;
         tmo_d    = '0;
      end else begin
         case (state_q)
            StEnterA, StEnterB: begin
               if (eq_stb) begin
                  if (state_q == StEnterB) begin
                     alu_b_d     = (cnt_q == '0) ? 32'd0 : entry_val(mag_q, neg_q);
                     alu_start_d = 1'b1;
                     tmo_d       = '0;
                     state_d     = StWaitAlu;
                  end
               end else if (op_stb) begin
                  if (state_q == StEnterA) begin
                     alu_a_d  = entry_val(mag_q, neg_q);
                     alu_op_d = op_sel;
                     mag_d    = '0;
                     cnt_d    = '0;
                     neg_d    = 1'b0;
                     state_d  = StEnterB;
                  end else if (cnt_q == '0) begin
                     alu_op_d = op_sel;
                  end
               end else if (neg_stb) begin
                  neg_d = ~neg_q;
               end else if (digit_ok && (cnt_q < CntW'(MAX_DIGITS))) begin
                  mag_d = mag_q * 32'd10 + {28'd0, digit};
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StWaitAlu: begin
               if (alu_done) begin
                  result_d = alu_result;
                  mag_d    = '0;
                  cnt_d    = '0;
                  neg_d    = 1'b0;
                  state_d  = StShow;
               end else if ((TIMEOUT != 0) && (tmo_q == TIMEOUT - 1)) begin
                  state_d = StErr;
               end else begin
                  tmo_d = tmo_q + 32'd1;
               end
            end
            StShow: begin
               if (eq_stb) begin
                  // '=' is ignored here but still masks lower-priority keys.
               end else if (op_stb) begin
                  alu_a_d  = result_q;
                  alu_op_d = op_sel;
                  mag_d    = '0;
                  cnt_d    = '0;
                  neg_d    = 1'b0;
                  state_d  = StEnterB;
               end else if (neg_stb) begin
                  // Sign toggle has no meaning on a displayed result.
               end else if (digit_ok) begin
                  mag_d   = {28'd0, digit};
                  cnt_d   = CntW'(1);
                  neg_d   = 1'b0;
                  state_d = StEnterA;
               end
            end
            default: ;
         endcase
      end

      // Display follows the next state so it changes on the same edge as the state.
      case (state_d)
         StEnterA, StEnterB: disp_d = entry_val(mag_d, neg_d);
         StShow:             disp_d = result_d;
         StWaitAlu:          disp_d = disp_q;
         default:            disp_d = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StEnterA;
         mag_q       <= '0;
         cnt_q       <= '0;
         neg_q       <= 1'b0;
         result_q    <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         alu_start_q <= 1'b0;
         disp_q      <= '0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         mag_q       <= mag_d;
         cnt_q       <= cnt_d;
         neg_q       <= neg_d;
         result_q    <= result_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         alu_start_q <= alu_start_d;
         disp_q      <= disp_d;
         tmo_q       <= tmo_d;
      end
   end

   assign alu_start  = alu_start_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_op     = alu_op_q;
   assign disp_value = disp_q;
   assign state      = state_q;
   assign err        = (state_q == StErr);

endmodule
